// File: rtl/tug_pkg.sv
// Shared types and default constants for the tug-of-war referee.
package tug_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    WIN   = 2'd2,
    OVER  = 2'd3
  } ref_state_t;

  localparam int DEF_SCORE_W     = 3;
  localparam int DEF_MAX_SCORE   = 7;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

// File: rtl/press_detect.sv
// Rising-edge detector for one already-synchronized player key.
module press_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic rise
);

  logic keyQ;

  // Reset loads the live level, so a key held through reset never counts as a press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      keyQ <= key;
    end else begin
      keyQ <= key;
    end
  end

  assign rise = key & ~keyQ;

endmodule

// File: rtl/tug_referee.sv
// Round sequencer: turns key presses into step pulses, scores end-cell wins
// and re-serves the playfield until one player reaches the match score.
module tug_referee
  import tug_pkg::*;
#(
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int MAX_SCORE   = DEF_MAX_SCORE,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               KeyL,
  input  logic               KeyR,
  input  logic               winL,
  input  logic               winR,
  output logic               L,
  output logic               R,
  output logic               roundReset,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               gameOver,
  output logic               champL
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  ref_state_t        state;
  ref_state_t        stateNext;
  logic              pressL;
  logic              pressR;
  logic              lNext;
  logic              rNext;
  logic              incL;
  logic              incR;
  logic [HOLD_W-1:0] holdCount;
  logic              holdLast;

  press_detect uPressL (
    .Clock (Clock),
    .Reset (Reset),
    .key   (KeyL),
    .rise  (pressL)
  );

  press_detect uPressR (
    .Clock (Clock),
    .Reset (Reset),
    .key   (KeyR),
    .rise  (pressR)
  );

  assign holdLast = (holdCount == HOLD_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= SERVE;
    end else begin
      state <= stateNext;
    end
  end

  // Win flags outrank presses; simultaneous presses cancel each other.
  always_comb begin
    stateNext = state;
    lNext     = 1'b0;
    rNext     = 1'b0;
    incL      = 1'b0;
    incR      = 1'b0;
    case (state)
      SERVE: stateNext = PLAY;
      PLAY: begin
        if (winL && winR) begin
          stateNext = SERVE;
        end else if (winL) begin
          stateNext = WIN;
          incL      = 1'b1;
        end else if (winR) begin
          stateNext = WIN;
          incR      = 1'b1;
        end else begin
          lNext = pressL & ~pressR;
          rNext = pressR & ~pressL;
        end
      end
      WIN: begin
        if (holdLast) begin
          stateNext = ((scoreL == MAX_S) || (scoreR == MAX_S)) ? OVER : SERVE;
        end
      end
      OVER:    stateNext = OVER;
      default: stateNext = SERVE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset || (state != WIN)) begin
      holdCount <= '0;
    end else if (!holdLast) begin
      holdCount <= holdCount + 1'b1;
    end
  end

  // Scores saturate at the match score rather than wrapping.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      L      <= 1'b0;
      R      <= 1'b0;
      scoreL <= '0;
      scoreR <= '0;
    end else begin
      L <= lNext;
      R <= rNext;
      if (incL && (scoreL != MAX_S)) begin
        scoreL <= scoreL + 1'b1;
      end
      if (incR && (scoreR != MAX_S)) begin
        scoreR <= scoreR + 1'b1;
      end
    end
  end

  assign roundReset = (state == SERVE);
  assign gameOver   = (state == OVER);
  assign champL     = (state == OVER) && (scoreL == MAX_S);

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for tug_referee with default parameters (MAX_SCORE=7, HOLD_CYCLES=4).
module tb_tug_referee;
  import tug_pkg::*;

  logic       Clock;
  logic       Reset;
  logic       KeyL;
  logic       KeyR;
  logic       winL;
  logic       winR;
  logic       L;
  logic       R;
  logic       roundReset;
  logic [2:0] scoreL;
  logic [2:0] scoreR;
  logic       gameOver;
  logic       champL;

  int checkCount;
  int passCount;

  tug_referee dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KeyL       (KeyL),
    .KeyR       (KeyR),
    .winL       (winL),
    .winR       (winR),
    .L          (L),
    .R          (R),
    .roundReset (roundReset),
    .scoreL     (scoreL),
    .scoreR     (scoreR),
    .gameOver   (gameOver),
    .champL     (champL)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic kl, input logic kr, input logic wl, input logic wr);
    KeyL = kl;
    KeyR = kr;
    winL = wl;
    winR = wr;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic checkPulses(input string tag, input logic expL, input logic expR);
    checkOutput({tag, " L"}, {7'd0, L}, {7'd0, expL});
    checkOutput({tag, " R"}, {7'd0, R}, {7'd0, expR});
  endtask

  // One scoring point from PLAY back to PLAY (or into OVER on the last point).
  task automatic scorePoint(input logic left, input logic [2:0] expScore, input logic final_);
    applyStimulus(KeyL, KeyR, left, ~left);
    tick();
    applyStimulus(KeyL, KeyR, 1'b0, 1'b0);
    if (left) checkOutput("point scoreL", {5'd0, scoreL}, {5'd0, expScore});
    else      checkOutput("point scoreR", {5'd0, scoreR}, {5'd0, expScore});
    checkOutput("point state WIN", 8'(dut.state), 8'(WIN));
    repeat (4) tick();
    if (final_) begin
      checkOutput("final state OVER", 8'(dut.state), 8'(OVER));
    end else begin
      checkOutput("reserve roundReset", {7'd0, roundReset}, 8'd1);
      tick();
      checkOutput("replay state", 8'(dut.state), 8'(PLAY));
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset and first serve
    tick();
    Reset = 1'b0;
    checkOutput("reset roundReset", {7'd0, roundReset}, 8'd1);
    checkOutput("reset scoreL", {5'd0, scoreL}, 8'd0);
    checkOutput("reset scoreR", {5'd0, scoreR}, 8'd0);
    checkOutput("reset gameOver", {7'd0, gameOver}, 8'd0);
    checkPulses("reset", 1'b0, 1'b0);
    tick();
    checkOutput("play roundReset", {7'd0, roundReset}, 8'd0);

    // KeyL held 5 cycles gives exactly one L pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkPulses("keyL edge", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkPulses("keyL held", 1'b0, 1'b0);
      checkOutput("keyL held roundReset", {7'd0, roundReset}, 8'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkPulses("keyL released", 1'b0, 1'b0);

    // Simultaneous presses cancel; later lone KeyR press pulses R
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkPulses("both keys", 1'b0, 1'b0);
    tick();
    checkPulses("both held", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkPulses("keyR released", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkPulses("keyR repress", 1'b0, 1'b1);
    tick();
    checkPulses("keyR after pulse", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // winL with KeyL rising the same cycle: press discarded, KeyL held through round
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("winL scoreL", {5'd0, scoreL}, 8'd1);
    checkOutput("winL scoreR", {5'd0, scoreR}, 8'd0);
    checkPulses("winL press dropped", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold state", 8'(dut.state), 8'(WIN));
      checkOutput("hold roundReset", {7'd0, roundReset}, 8'd0);
      checkPulses("hold", 1'b0, 1'b0);
    end
    tick();
    checkOutput("serve roundReset", {7'd0, roundReset}, 8'd1);
    checkPulses("serve", 1'b0, 1'b0);
    tick();
    checkOutput("replay roundReset", {7'd0, roundReset}, 8'd0);
    checkPulses("held key into play", 1'b0, 1'b0);
    tick();
    checkPulses("held key play2", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Both win flags together: no score, straight to SERVE
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("double win roundReset", {7'd0, roundReset}, 8'd1);
    checkOutput("double win scoreL", {5'd0, scoreL}, 8'd1);
    checkOutput("double win scoreR", {5'd0, scoreR}, 8'd0);
    tick();
    checkOutput("double win replay", 8'(dut.state), 8'(PLAY));

    // Left wins through to 7
    for (int s = 2; s <= 7; s++) begin
      scorePoint(1'b1, 3'(s), (s == 7));
    end
    checkOutput("over gameOver", {7'd0, gameOver}, 8'd1);
    checkOutput("over champL", {7'd0, champL}, 8'd1);
    checkOutput("over scoreL", {5'd0, scoreL}, 8'd7);

    // Match over: keys and win flags ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkPulses("over keys", 1'b0, 1'b0);
    checkOutput("over scoreR frozen", {5'd0, scoreR}, 8'd0);
    checkOutput("over scoreL frozen", {5'd0, scoreL}, 8'd7);
    checkOutput("over still", {7'd0, gameOver}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh match, reset during WIN with scoreR=3
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("rematch gameOver", {7'd0, gameOver}, 8'd0);
    checkOutput("rematch champL", {7'd0, champL}, 8'd0);
    checkOutput("rematch scoreL", {5'd0, scoreL}, 8'd0);
    tick();
    scorePoint(1'b0, 3'd1, 1'b0);
    scorePoint(1'b0, 3'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("third R scoreR", {5'd0, scoreR}, 8'd3);
    tick();
    checkOutput("mid hold state", 8'(dut.state), 8'(WIN));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("midhold reset scoreR", {5'd0, scoreR}, 8'd0);
    checkOutput("midhold reset scoreL", {5'd0, scoreL}, 8'd0);
    checkOutput("midhold reset state", 8'(dut.state), 8'(SERVE));
    checkOutput("midhold reset roundReset", {7'd0, roundReset}, 8'd1);
    checkOutput("midhold reset gameOver", {7'd0, gameOver}, 8'd0);
    checkPulses("midhold reset", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
# tug_referee

Round sequencer for the tug-of-war light chain. It edge-detects the two player keys and arbitrates them into single-cycle `L`/`R` step pulses for the light cells. It watches the end cells' `winner` flags, keeps per-player scores, and re-serves the playfield after each point until one player reaches the match score.

## Interface
Parameters:
- `SCORE_W`, default 3: width of each score counter.
- `MAX_SCORE`, default 7: points that end the match. Must be ≤ 2^SCORE_W−1 and ≥ 1.
- `HOLD_CYCLES`, default 4: cycles the WIN state is held before re-serve. Must be ≥ 1.

Ports:
- `Clock`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `KeyL`, in, 1: left player key, level, already synchronized.
- `KeyR`, in, 1: right player key, level, already synchronized.
- `winL`, in, 1: `winner` from the leftmost cell.
- `winR`, in, 1: `winner` from the rightmost cell.
- `L`, out, 1: one-cycle left-step pulse to all cells.
- `R`, out, 1: one-cycle right-step pulse to all cells.
- `roundReset`, out, 1: playfield reset to all cells; centre light on.
- `scoreL`, out, SCORE_W: left score.
- `scoreR`, out, SCORE_W: right score.
- `gameOver`, out, 1: match finished.
- `champL`, out, 1: left player won the match. Valid when `gameOver`=1.

## Operation
- States: SERVE, PLAY, WIN, OVER.
- Reset forces the following, all on the next edge:
  - state=SERVE
  - scores=0
  - `L`=`R`=0
  - `gameOver`=`champL`=0
  - hold counter=0
  - key history registers = current key levels, so a key held through reset is not a press.
- SERVE:
  - `roundReset`=1 (Moore).
  - Unconditional transition to PLAY next cycle.
- PLAY:
  - Press detection: pressL = `KeyL` & ~KeyL_q; likewise pressR.
  - pressL only: `L`=1 next cycle.
  - pressR only: `R`=1 next cycle.
  - pressL and pressR in the same cycle: both cancelled, no pulse.
  - `winL` xor `winR`: go to WIN and increment that player's score.
  - Both win flags at once: no score change, go to SERVE.
  - A win flag has priority over a press in the same cycle: the press is discarded.
- WIN:
  - `L`=`R`=0.
  - Hold counter counts 0..HOLD_CYCLES−1.
  - At the terminal count: go to OVER if either score equals MAX_SCORE, otherwise go to SERVE.
- OVER:
  - `gameOver`=1; `champL` = (scoreL==MAX_SCORE).
  - Keys and win flags are ignored; the only exit is Reset.
- Key history registers update every cycle in every state. A key held across SERVE or WIN therefore produces no press on entering PLAY.
- Presses outside PLAY are discarded, not queued.
- Scores saturate at MAX_SCORE and never wrap.

## Timing
- Press edge at cycle N (in PLAY) → `L`/`R` high during N+1 only; the output is registered.
- A key held for many cycles produces exactly one pulse. A new pulse requires the key to go low for ≥1 cycle and then high again.
- Win flag seen at cycle N → state=WIN at N+1. The score is registered and visible at N+1.
- WIN lasts exactly HOLD_CYCLES cycles. SERVE then lasts exactly 1 cycle, with `roundReset` high. PLAY starts on the following cycle.
- Reset mid-round or mid-hold: on the next edge all outputs return to reset values; `roundReset`=1 because the state is SERVE.
- `L` and `R` are never high together, and never high while `roundReset`=1.

## Structure
- Package `tug_pkg`:
  - state enum `ref_state_t` {SERVE, PLAY, WIN, OVER}
  - default constants for SCORE_W, MAX_SCORE, HOLD_CYCLES
- Sub-module `press_detect`, instantiated twice (left and right):
  - one history flop plus the rise output
  - synchronous active-high reset that loads the current key level
- Top level contains the state register, next-state logic, hold counter, score counters and output registers.

## Test plan
- Reset with both keys low, then hold KeyL for 5 cycles → exactly one `L` pulse, 1 cycle after the rising edge. `R` never asserted. `roundReset`=1 only in the first post-reset cycle.
- KeyL and KeyR rise in the same PLAY cycle → no pulse on `L` or `R`. KeyR then released and re-pressed → one `R` pulse.
- `winL` pulse in PLAY (HOLD_CYCLES=4) → scoreL 0→1 next cycle. WIN held 4 cycles, `roundReset` high 1 cycle, then PLAY. KeyL held throughout produces no pulse.
- `winL` and `winR` asserted together → scores unchanged, SERVE next cycle.
- Seven left wins (MAX_SCORE=7) → scoreL=7, `gameOver`=1, `champL`=1 after the hold. Further key presses and win flags have no effect.
- Reset asserted during WIN with scoreR=3 → next cycle scores=0, state=SERVE, `gameOver`=0.
